start_rdy_timer: RTL and testbench

//  Programmable delay timer that handshakes with the START/RDY control FSM.

---
 rtl/start_rdy_timer.sv | 104 ++++++++++
 tb/tb_start_rdy_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/start_rdy_timer.sv
// Programmable START/RDY delay timer: drops RDY for max(DELAY,1) prescaled ticks.
// Ports: clk, reset, START, DELAY, ABORT in; RDY, DONE, REMAIN out (registered).
module start_rdy_timer #(
  parameter int PRESCALE  = 1000,
  parameter int CNT_W     = 16,
  parameter bit RETRIGGER = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             START,
  input  logic [CNT_W-1:0] DELAY,
  input  logic             ABORT,
  output logic             RDY,
  output logic             DONE,
  output logic [CNT_W-1:0] REMAIN
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             rdy_q, rdy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] dly_eff;
  logic             tick;

  // A zero DELAY still produces one full tick of delay.
  assign dly_eff = (DELAY == '0) ? CNT_W'(1) : DELAY;
  assign tick    = (pre_q == PRE_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pre_q    <= '0;
      remain_q <= '0;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      remain_q <= remain_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    remain_d = remain_q;
    rdy_d    = rdy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          state_d  = RUN;
          remain_d = dly_eff;
          pre_d    = '0;
          rdy_d    = 1'b0;
        end
      end
      RUN: begin
        if (ABORT) begin
          state_d  = IDLE;
          remain_d = '0;
          pre_d    = '0;
          rdy_d    = 1'b1;
        end else if (START && RETRIGGER) begin
          // Reload wins over a coincident expiry: no DONE, RDY stays low.
          remain_d = dly_eff;
          pre_d    = '0;
        end else if (tick) begin
          pre_d = '0;
          if (remain_q > CNT_W'(1)) begin
            remain_d = remain_q - CNT_W'(1);
          end else begin
            state_d  = IDLE;
            remain_d = '0;
            rdy_d    = 1'b1;
            done_d   = 1'b1;
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign RDY    = rdy_q;
  assign DONE   = done_q;
  assign REMAIN = remain_q;

endmodule

// File: tb/tb_start_rdy_timer.sv
// Directed bench for start_rdy_timer: three instances
// (PRESCALE=4 no-retrigger, PRESCALE=4 retrigger, PRESCALE=1).
module tb_start_rdy_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort;
  logic [7:0] delay;
  logic       start1, abort1;
  logic [7:0] delay1;

  logic       rdy_a, done_a, rdy_b, done_b, rdy_c, done_c;
  logic [7:0] rem_a, rem_b, rem_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  start_rdy_timer #(.PRESCALE(4), .CNT_W(8), .RETRIGGER(1'b0)) u_a (
    .clk(clk), .reset(reset), .START(start), .DELAY(delay),
    .ABORT(abort), .RDY(rdy_a), .DONE(done_a), .REMAIN(rem_a)
  );

  start_rdy_timer #(.PRESCALE(4), .CNT_W(8), .RETRIGGER(1'b1)) u_b (
    .clk(clk), .reset(reset), .START(start), .DELAY(delay),
    .ABORT(abort), .RDY(rdy_b), .DONE(done_b), .REMAIN(rem_b)
  );

  start_rdy_timer #(.PRESCALE(1), .CNT_W(8), .RETRIGGER(1'b0)) u_c (
    .clk(clk), .reset(reset), .START(start1), .DELAY(delay1),
    .ABORT(abort1), .RDY(rdy_c), .DONE(done_c), .REMAIN(rem_c)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse START on instance set 0 (a/b) or 1 (c); returns just after accept edge.
  task automatic pulse(input int which);
    if (which == 0) start = 1'b1; else start1 = 1'b1;
    step(1);
    if (which == 0) start = 1'b0; else start1 = 1'b0;
  endtask

  task automatic measure_low(input int which, input int limit, output int n);
    logic r;
    n = 0;
    r = (which == 0) ? rdy_a : (which == 1) ? rdy_b : rdy_c;
    while (!r && n < limit) begin
      step(1);
      n++;
      r = (which == 0) ? rdy_a : (which == 1) ? rdy_b : rdy_c;
    end
  endtask

  int n, n2, n5, bad, seen;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; delay = 8'd0;
    start1 = 1'b0; abort1 = 1'b0; delay1 = 8'd0;
    step(2);
    chk("rst_rdy", int'(rdy_a), 1);
    chk("rst_done", int'(done_a), 0);
    chk("rst_rem", int'(rem_a), 0);
    chk("rst_rdy_c", int'(rdy_c), 1);
    reset = 1'b0;
    step(1);

    // Basic: DELAY=3, later DELAY change must not matter
    delay = 8'd3;
    pulse(0);
    delay = 8'd200;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (rdy_a !== 1'b0 || done_a !== 1'b0) bad++;
      if (int'(rem_a) != 3 - k / 4) bad++;
      step(1);
    end
    chk("basic_run", bad, 0);
    chk("basic_rdy_up", int'(rdy_a), 1);
    chk("basic_done", int'(done_a), 1);
    chk("basic_rem0", int'(rem_a), 0);
    step(1);
    chk("basic_done_1cyc", int'(done_a), 0);

    // DELAY=0 behaves as DELAY=1
    delay = 8'd0;
    pulse(0);
    measure_low(0, 50, n);
    chk("zero_low", n, 4);
    chk("zero_done", int'(done_a), 1);
    step(2);

    // PRESCALE=1, DELAY=255
    delay1 = 8'd255;
    pulse(1);
    bad = 0;
    n = 0;
    while (!rdy_c && n < 300) begin
      if (int'(rem_c) != 255 - n) bad++;
      step(1);
      n++;
    end
    chk("p1_low", n, 255);
    chk("p1_rem_seq", bad, 0);
    chk("p1_done", int'(done_c), 1);
    delay1 = 8'd0;
    pulse(1);
    measure_low(2, 20, n);
    chk("p1_zero_low", n, 1);
    step(2);

    // Abort at cycle 7 of DELAY=5
    delay = 8'd5;
    pulse(0);
    step(6);
    chk("abort_rem_pre", int'(rem_a), 4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("abort_rdy", int'(rdy_a), 1);
    chk("abort_rem", int'(rem_a), 0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (done_a) seen++;
      step(1);
    end
    chk("abort_no_done", seen, 0);

    // ABORT+START in IDLE
    abort = 1'b1;
    start = 1'b1;
    step(1);
    abort = 1'b0;
    start = 1'b0;
    chk("abst_rdy", int'(rdy_a), 1);
    chk("abst_rem", int'(rem_a), 0);
    step(1);
    chk("abst_rdy2", int'(rdy_a), 1);

    // Retrigger: DELAY=2, second START at cycle 6
    delay = 8'd2;
    pulse(0);
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("rt_a_rem6", int'(rem_a), 1);
    chk("rt_b_rem6", int'(rem_b), 2);
    step(1);
    chk("rt_a_rdy7", int'(rdy_a), 0);
    step(1);
    chk("rt_a_rdy8", int'(rdy_a), 1);
    chk("rt_a_done8", int'(done_a), 1);
    chk("rt_b_rdy8", int'(rdy_b), 0);
    chk("rt_b_done8", int'(done_b), 0);
    step(5);
    chk("rt_b_rdy13", int'(rdy_b), 0);
    step(1);
    chk("rt_b_rdy14", int'(rdy_b), 1);
    chk("rt_b_done14", int'(done_b), 1);
    step(2);

    // Reset mid-RUN
    delay = 8'd5;
    pulse(0);
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_rdy", int'(rdy_a), 1);
    chk("midrst_rem", int'(rem_a), 0);
    chk("midrst_done", int'(done_a), 0);
    step(1);

    // START/RDY FSM loop: S1 start -> S2 wait -> S3 -> S4 start -> S5 wait
    delay = 8'd3;
    pulse(0);
    measure_low(0, 100, n2);
    step(1);
    pulse(0);
    measure_low(0, 100, n5);
    chk("fsm_s2_wait", n2, 12);
    chk("fsm_s5_wait", n5, 12);
    // X low: FSM stays in S0, timer stays idle
    step(10);
    chk("fsm_x0_rdy", int'(rdy_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
